dice_roll_controller: RTL
=========================

// Module: dice_roll_controller
// PURPOSE
//   Consumes Enable ticks from the rate divider and turns them into a dice roll.
//   While roll is held, the face value steps once per tick.
//   On release, the value keeps stepping for SETTLE_TICKS slower ticks, then
//   freezes and emits a one-cycle done pulse.
//   Drives the divider's rate select and run gate; feeds the board/piece logic.
// PARAMETERS
//   FACES         6   highest face value; value range is 1..FACES (FACES <= 7)
//   SETTLE_TICKS  8   ticks stepped after roll release (must be >= 1)
//   CNT_W         4   settle counter width; must hold SETTLE_TICKS
// PORTS
//   clock     in   1  system clock, 50 MHz
//   Clear_b   in   1  asynchronous active-low reset
//   roll      in   1  roll button level, already synchronised; 1 = rolling
//   tick      in   1  divider Enable; one clock wide per period
//   rate_sel  out  2  divider rate: 2'b00 in ROLL, 2'b10 in SETTLE, else 2'b00
//   div_run   out  1  divider run gate; 1 in ROLL and SETTLE
//   value     out  3  current face, 1..FACES
//   rolling   out  1  1 while in ROLL or SETTLE
//   done      out  1  one-cycle pulse; value is final in that cycle
// BEHAVIOUR
//   Reset (Clear_b=0, async)
//     state=IDLE, value=1, settle_cnt=0, done=0, rolling=0, div_run=0,
//     rate_sel=2'b00.
//   All outputs are registered, or decoded from registered state only.
//   Step rule: value <= (value == FACES) ? 1 : value + 1.
//   States
//     IDLE
//       Holds value; tick ignored.
//       roll=1 -> ROLL (no step in the transition cycle).
//     ROLL
//       Each tick=1 cycle steps value.
//       roll=0 -> SETTLE, settle_cnt <= SETTLE_TICKS.
//       If tick=1 in that same cycle, the step still happens.
//     SETTLE
//       Each tick=1 cycle steps value and decrements settle_cnt.
//       tick with settle_cnt==1 -> DONE.
//       roll=1 -> ROLL; this has priority over tick, and settle_cnt is
//       abandoned (reloaded on the next release).
//     DONE
//       Exactly one cycle; done=1, value frozen.
//       -> IDLE unconditionally, even if roll=1.
//       A new roll is accepted from IDLE on the next cycle.
//   Outputs decoded from registered state
//     rolling=1 in ROLL/SETTLE.
//     done=1 only in DONE.
//     rate_sel/div_run as listed in PORTS.
//   Latency
//     roll rise -> rolling=1: 1 cycle.
//     Last settle tick -> done=1: 1 cycle.
//   Boundaries
//     Wrap FACES->1 in both ROLL and SETTLE.
//     Ticks in IDLE/DONE never change value.
//     Reset mid-roll returns to IDLE with value=1 immediately.
// TESTING
//   1. Reset: Clear_b=0 mid-SETTLE -> same-edge async: value=1, rolling=0,
//      done=0, div_run=0.
//   2. roll=1, 8 ticks from value=1 -> value sequence 2,3,4,5,6,1,2,3;
//      rate_sel=00, div_run=1.
//   3. Release roll at value=3, 8 ticks -> value 4,5,6,1,2,3,4,5; done pulse
//      1 cycle after the 8th tick; value=5 held; rate_sel=10 during SETTLE.
//   4. Re-press roll after 3 settle ticks -> back to ROLL, no done;
//      next release runs a full 8 ticks.
//   5. Same-cycle tick and roll fall in ROLL -> value steps once, SETTLE
//      entered with settle_cnt=8.
//   6. Ticks in IDLE, and roll=1 held through DONE -> value unchanged, done
//      exactly 1 cycle, ROLL re-entered from IDLE on the following cycle.

Source files
------------

// File: rtl/dice_roll_controller_if.sv
// Handshake bundle between the dice roll controller, its rate divider and the board logic.
interface dice_roll_controller_if;
   logic       roll;
   logic       tick;
   logic [1:0] rate_sel;
   logic       div_run;
   logic [2:0] value;
   logic       rolling;
   logic       done;

   modport master (
      output roll, tick,
      input  rate_sel, div_run, value, rolling, done
   );

   modport slave (
      input  roll, tick,
      output rate_sel, div_run, value, rolling, done
   );
endinterface

// File: rtl/dice_roll_controller.sv
// Dice roll sequencer: steps the face on divider ticks while rolling, then settles
// for a fixed number of slower ticks and pulses done with the final face.
//
// state  | meaning
// IDLE   | face held, waiting for roll press
// ROLL   | roll held, face steps on every tick (fast rate)
// SETTLE | roll released, face steps on ticks (slow rate) until settle count expires
// DONE   | one-cycle done pulse, face final
module dice_roll_controller #(
   parameter int FACES        = 6,
   parameter int SETTLE_TICKS = 8,
   parameter int CNT_W        = 4
) (
   input  logic                   clock,
   input  logic                   Clear_b,
   dice_roll_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROLL   = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       value, value_nxt;
   logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
   logic [2:0]       value_step;

   assign value_step = (value == 3'(FACES)) ? 3'd1 : value + 3'd1;

   always_ff @(posedge clock or negedge Clear_b) begin
      if (!Clear_b) begin
         state      <= IDLE;
         value      <= 3'd1;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         value      <= value_nxt;
         settle_cnt <= settle_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      value_nxt      = value;
      settle_cnt_nxt = settle_cnt;
      unique case (state)
         IDLE: begin
            if (bus.roll) state_nxt = ROLL;
         end
         ROLL: begin
            if (bus.tick) value_nxt = value_step;
            if (!bus.roll) begin
               state_nxt      = SETTLE;
               settle_cnt_nxt = CNT_W'(SETTLE_TICKS);
            end
         end
         SETTLE: begin
            // A re-press wins over a coincident tick; the count is reloaded on release.
            if (bus.roll) begin
               state_nxt = ROLL;
            end else if (bus.tick) begin
               value_nxt      = value_step;
               settle_cnt_nxt = settle_cnt - CNT_W'(1);
               if (settle_cnt == CNT_W'(1)) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.value    = value;
   assign bus.rolling  = (state == ROLL) || (state == SETTLE);
   assign bus.div_run  = (state == ROLL) || (state == SETTLE);
   assign bus.done     = (state == DONE);
   assign bus.rate_sel = (state == SETTLE) ? 2'b10 : 2'b00;

endmodule
